midi_voice_allocator: RTL and testbench

// - Sits between the SPI slave byte stream and the DDS voice bank.
// - Parses MIDI Note-On (0x9n) and Note-Off (0x8n) messages, with running status.
// - Assigns each note to one of NUM_VOICES voices and drives per-voice note, velocity, gate and trigger.
// - The DDS side reads voice_note/voice_gate directly; it no longer parses MIDI itself.

---
 rtl/midi_pkg.sv | 20 ++
 rtl/voice_picker.sv | 53 +++++
 rtl/midi_voice_allocator.sv | 139 +++++++++++++
 tb/tb_midi_voice_allocator.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI constants, widths and the parser state encoding used by the voice
// allocator and its voice picker.
package midi_pkg;

  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [7:0] MIDI_RT_MIN   = 8'hF8;

  localparam int NOTE_W = 7;
  localparam int VEL_W  = 7;
  localparam int AGE_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA1 = 2'd1,
    ST_DATA2 = 2'd2,
    ST_ALLOC = 2'd3
  } parse_state_e;

endpackage

// File: rtl/voice_picker.sv
// Combinational voice choice for a Note-On: retrigger a gated voice holding the same
// note, else the lowest free voice, else the oldest voice (lowest index on age ties).
module voice_picker
  import midi_pkg::*;
#(
  parameter int NUM_VOICES = 8
) (
  input  logic [NUM_VOICES-1:0]        gate_i,
  input  logic [NOTE_W*NUM_VOICES-1:0] notes_i,
  input  logic [AGE_W*NUM_VOICES-1:0]  ages_i,
  input  logic [NOTE_W-1:0]            note_i,
  output logic [NUM_VOICES-1:0]        sel_o,
  output logic                         hit_o
);

  localparam logic [NUM_VOICES-1:0] ONE = {{(NUM_VOICES-1){1'b0}}, 1'b1};

  logic [NUM_VOICES-1:0] match;
  logic [NUM_VOICES-1:0] free;
  logic [NUM_VOICES-1:0] steal;
  logic [AGE_W-1:0]      best_age;

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_cmp
    assign match[gi] = gate_i[gi] && (notes_i[gi*NOTE_W +: NOTE_W] == note_i);
  end

  assign free  = ~gate_i;
  assign hit_o = |match;

  // Strict '>' keeps the earliest voice among equally old candidates.
  always_comb begin
    steal    = ONE;
    best_age = ages_i[AGE_W-1:0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (ages_i[i*AGE_W +: AGE_W] > best_age) begin
        best_age = ages_i[i*AGE_W +: AGE_W];
        steal    = ONE << i;
      end
    end
  end

  // x & (~x + 1) isolates the lowest set bit, giving a one-hot select.
  always_comb begin
    if (hit_o) begin
      sel_o = match & (~match + ONE);
    end else if (|free) begin
      sel_o = free & (~free + ONE);
    end else begin
      sel_o = steal;
    end
  end

endmodule

// File: rtl/midi_voice_allocator.sv
// MIDI Note-On/Note-Off parser with running status feeding a polyphonic voice
// allocator; drives per-voice note, velocity, gate and a one-cycle retrigger pulse.
module midi_voice_allocator
  import midi_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int OMNI       = 1,
  parameter int CHANNEL    = 0
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  output logic                         rx_ready,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
  output logic [VEL_W*NUM_VOICES-1:0]  voice_vel,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES-1:0]        voice_trig
);

  localparam logic [3:0]       CHAN    = 4'(CHANNEL);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

  parse_state_e       state_q;
  logic               on_q;
  logic [NOTE_W-1:0]  note_q;
  logic [VEL_W-1:0]   vel_q;
  logic               rx_ready_q;

  logic [NOTE_W-1:0]  vnote_q [NUM_VOICES];
  logic [VEL_W-1:0]   vvel_q  [NUM_VOICES];
  logic [AGE_W-1:0]   age_q   [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q;
  logic [NUM_VOICES-1:0] trig_q;

  logic accept, is_rt, chan_ok, is_note_msg;
  logic alloc, is_off, hit;
  logic [NUM_VOICES-1:0]        sel;
  logic [NOTE_W*NUM_VOICES-1:0] note_flat;
  logic [AGE_W*NUM_VOICES-1:0]  age_flat;

  assign accept      = rx_valid && rx_ready_q;
  assign is_rt       = rx_data >= MIDI_RT_MIN;
  assign chan_ok     = (OMNI != 0) || (rx_data[3:0] == CHAN);
  assign is_note_msg = chan_ok &&
                       ((rx_data[7:4] == MIDI_NOTE_ON) || (rx_data[7:4] == MIDI_NOTE_OFF));

  // A status byte resyncs the parser from any state, so DATA1/DATA2 share IDLE's handling.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_IDLE;
      on_q       <= 1'b0;
      note_q     <= '0;
      vel_q      <= '0;
      rx_ready_q <= 1'b0;
    end else begin
      rx_ready_q <= 1'b1;
      if (state_q == ST_ALLOC) begin
        state_q <= ST_DATA1;
      end else if (accept && !is_rt) begin
        if (rx_data[7]) begin
          if (is_note_msg) begin
            on_q    <= (rx_data[7:4] == MIDI_NOTE_ON);
            state_q <= ST_DATA1;
          end else begin
            state_q <= ST_IDLE;
          end
        end else if (state_q == ST_DATA1) begin
          note_q  <= rx_data[NOTE_W-1:0];
          state_q <= ST_DATA2;
        end else if (state_q == ST_DATA2) begin
          vel_q      <= rx_data[VEL_W-1:0];
          state_q    <= ST_ALLOC;
          rx_ready_q <= 1'b0;
        end
      end
    end
  end

  assign alloc  = (state_q == ST_ALLOC);
  assign is_off = !on_q || (vel_q == '0);

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_flat
    assign note_flat[gi*NOTE_W +: NOTE_W] = vnote_q[gi];
    assign age_flat[gi*AGE_W +: AGE_W]    = age_q[gi];
    assign voice_vel[gi*VEL_W +: VEL_W]   = vvel_q[gi];
  end

  voice_picker #(
    .NUM_VOICES(NUM_VOICES)
  ) u_picker (
    .gate_i (gate_q),
    .notes_i(note_flat),
    .ages_i (age_flat),
    .note_i (note_q),
    .sel_o  (sel),
    .hit_o  (hit)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      gate_q <= '0;
      trig_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        vnote_q[i] <= '0;
        vvel_q[i]  <= '0;
        age_q[i]   <= '0;
      end
    end else begin
      trig_q <= '0;
      if (alloc) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (is_off) begin
            if (gate_q[i] && (vnote_q[i] == note_q)) begin
              gate_q[i] <= 1'b0;
            end
          end else if (sel[i]) begin
            // A retrigger already holds this note; only velocity and envelope restart.
            if (!hit) begin
              vnote_q[i] <= note_q;
            end
            vvel_q[i] <= vel_q;
            gate_q[i] <= 1'b1;
            trig_q[i] <= 1'b1;
            age_q[i]  <= '0;
          end else if (age_q[i] != AGE_MAX) begin
            age_q[i] <= age_q[i] + 4'd1;
          end
        end
      end
    end
  end

  assign rx_ready   = rx_ready_q;
  assign voice_note = note_flat;
  assign voice_gate = gate_q;
  assign voice_trig = trig_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Self-checking bench: scenario table, reset corner case and random MIDI byte stream
// compared against a message-level reference model of the allocator.
module tb_midi_voice_allocator;

  localparam int NV = 8;

  logic            clk = 1'b0;
  logic            nreset = 1'b0;
  logic            rx_valid = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_ready;
  logic [7*NV-1:0] voice_note;
  logic [7*NV-1:0] voice_vel;
  logic [NV-1:0]   voice_gate;
  logic [NV-1:0]   voice_trig;

  int errors = 0;
  int checks = 0;

  midi_voice_allocator #(.NUM_VOICES(NV), .OMNI(1), .CHANNEL(0)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .voice_note(voice_note),
    .voice_vel (voice_vel),
    .voice_gate(voice_gate),
    .voice_trig(voice_trig)
  );

  always #5 clk = ~clk;

  // Reference model: message-level view of the byte stream and the voice bank.
  int m_status;
  int m_pend [$];
  int m_note [NV];
  int m_vel  [NV];
  int m_age  [NV];
  bit m_gate [NV];
  logic [NV-1:0] m_trig;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_status = -1;
    m_pend.delete();
    m_trig = '0;
    for (int i = 0; i < NV; i++) begin
      m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0; m_gate[i] = 1'b0;
    end
  endtask

  task automatic model_exec(input bit on, input int n, input int v);
    int c;
    c = -1;
    m_trig = '0;
    if (!on || v == 0) begin
      for (int i = 0; i < NV; i++)
        if (m_gate[i] && m_note[i] == n) m_gate[i] = 1'b0;
      return;
    end
    for (int i = 0; i < NV; i++) if (c < 0 && m_gate[i] && m_note[i] == n) c = i;
    for (int i = 0; i < NV; i++) if (c < 0 && !m_gate[i]) c = i;
    if (c < 0) begin
      c = 0;
      for (int i = 1; i < NV; i++) if (m_age[i] > m_age[c]) c = i;
    end
    for (int i = 0; i < NV; i++) if (i != c && m_age[i] < NV - 1) m_age[i]++;
    m_note[c] = n; m_vel[c] = v; m_gate[c] = 1'b1; m_age[c] = 0;
    m_trig[c] = 1'b1;
  endtask

  task automatic model_byte(input logic [7:0] b, output bit done);
    done = 1'b0;
    if (b >= 8'hF8) return;
    if (b[7]) begin
      m_pend.delete();
      m_status = (b[7:4] == 4'h8 || b[7:4] == 4'h9) ? int'(b) : -1;
      return;
    end
    if (m_status < 0) return;
    m_pend.push_back(int'(b));
    if (m_pend.size() == 2) begin
      model_exec((m_status >> 4) == 9, m_pend[0], m_pend[1]);
      m_pend.delete();
      done = 1'b1;
    end
  endtask

  task automatic check_voices(input string tag, input logic [NV-1:0] exp_trig);
    logic [7*NV-1:0] en, ev;
    logic [NV-1:0]   eg;
    for (int i = 0; i < NV; i++) begin
      en[i*7 +: 7] = 7'(m_note[i]);
      ev[i*7 +: 7] = 7'(m_vel[i]);
      eg[i]        = m_gate[i];
    end
    chk({tag, "_note"}, voice_note, en);
    chk({tag, "_vel"},  voice_vel,  ev);
    chk({tag, "_gate"}, voice_gate, eg);
    chk({tag, "_trig"}, voice_trig, exp_trig);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    rx_valid = 1'b0;
    model_reset();
    #1;
    chk("rst_ready", rx_ready, 1'b0);
    check_voices("rst", '0);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_ready", rx_ready, 1'b1);
  endtask

  task automatic send(input logic [7:0] b);
    int guard;
    bit done;
    guard = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      errors++; checks++;
      $display("FAIL ready_timeout: got rx_ready=0 for 20 cycles expected 1");
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    model_byte(b, done);
    chk($sformatf("rdy_after_%02h", b), rx_ready, !done);
    if (done) begin
      @(posedge clk); #1;
      chk("rdy_after_alloc", rx_ready, 1'b1);
      check_voices("alloc", m_trig);
    end else begin
      chk("no_trig", voice_trig, '0);
    end
  endtask

  typedef struct {
    logic [8*20-1:0] b;
    int              len;
    logic [NV-1:0]   gate;
    logic [6:0]      n0, n1, v0;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [8*20-1:0] nine;
    logic [7:0] rb;
    int r;

    tbl[0] = '{{8'h90, 8'h3C, 8'h64}, 3, 8'h01, 7'h3C, 7'h00, 7'h64};
    tbl[1] = '{{8'h90, 8'h3C, 8'h40, 8'h3E, 8'h40}, 5, 8'h03, 7'h3C, 7'h3E, 7'h40};
    tbl[2] = '{{8'h90, 8'h3C, 8'h40, 8'h90, 8'h3C, 8'h00}, 6, 8'h00, 7'h3C, 7'h00, 7'h40};
    nine = {8'h90};
    for (int k = 0; k < 9; k++) nine = {nine[8*20-17:0], 8'(8'h30 + k), 8'h40};
    tbl[3] = '{nine, 19, 8'hFF, 7'h38, 7'h31, 7'h40};
    tbl[4] = '{{8'h90, 8'h3C, 8'hF8, 8'h40}, 4, 8'h01, 7'h3C, 7'h00, 7'h40};
    tbl[5] = '{{8'h90, 8'h3C, 8'h80, 8'h3C, 8'h00}, 5, 8'h00, 7'h00, 7'h00, 7'h00};
    tbl[6] = '{{8'h95, 8'h3C, 8'h40}, 3, 8'h01, 7'h3C, 7'h00, 7'h40};
    tbl[7] = '{{8'h90, 8'h3C, 8'h40, 8'h3C, 8'h50}, 5, 8'h01, 7'h3C, 7'h00, 7'h50};
    tbl[8] = '{{8'h90, 8'h3C, 8'h40, 8'hB0, 8'h3E, 8'h40}, 6, 8'h01, 7'h3C, 7'h00, 7'h40};
    tbl[9] = '{{8'h80, 8'h3C, 8'h40}, 3, 8'h00, 7'h00, 7'h00, 7'h00};

    model_reset();
    repeat (3) @(posedge clk);

    for (int t = 0; t < 10; t++) begin
      do_reset();
      for (int j = 0; j < tbl[t].len; j++)
        send(tbl[t].b[8*(tbl[t].len-1-j) +: 8]);
      chk($sformatf("tbl%0d_gate", t), voice_gate, tbl[t].gate);
      chk($sformatf("tbl%0d_note0", t), voice_note[6:0], tbl[t].n0);
      chk($sformatf("tbl%0d_note1", t), voice_note[13:7], tbl[t].n1);
      chk($sformatf("tbl%0d_vel0", t), voice_vel[6:0], tbl[t].v0);
    end

    // Asynchronous reset in the middle of a message drops it and the running status.
    do_reset();
    send(8'h90); send(8'h3C); send(8'h40);
    send(8'h90); send(8'h3C);
    @(posedge clk); #2;
    nreset = 1'b0;
    model_reset();
    #1;
    chk("midrst_ready", rx_ready, 1'b0);
    check_voices("midrst", '0);
    @(negedge clk);
    nreset = 1'b1;
    send(8'h40);
    send(8'h3E);
    send(8'h40);
    chk("midrst_gate", voice_gate, '0);

    // Random byte stream against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 12)       rb = 8'h90;
      else if (r < 18)  rb = 8'h80;
      else if (r < 20)  rb = 8'(8'h90 + $urandom_range(0, 15));
      else if (r < 22)  rb = ($urandom_range(0, 1) != 0) ? 8'hB0 : 8'hF0;
      else if (r < 25)  rb = ($urandom_range(0, 1) != 0) ? 8'hF8 : 8'hFE;
      else if (r < 65)  rb = 8'(8'h30 + $urandom_range(0, 11));
      else              rb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 127));
      send(rb);
    end
    check_voices("rand_end", '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
